// File: rtl/row_mem_ctrl.sv
// Round-robin sequencer for a shared array of row latches.
// Generates registered rs/wr/d timing and per-requester acks.
module row_mem_ctrl #(
  parameter int ROWS = 4,
  parameter int AW   = 2,
  parameter int DW   = 3
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   wd0,
  output logic            ack0,
  input  logic            req1,
  input  logic            we1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wd1,
  output logic            ack1,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            busy,
  output logic [ROWS-1:0] rs,
  output logic            wr,
  output logic [DW-1:0]   d,
  input  logic [DW-1:0]   mq
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    SAMPLE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic            last;
  logic            last_n;
  logic            gnt;
  logic            gnt_n;
  logic            op_we;
  logic            op_we_n;
  logic            op_ok;
  logic            op_ok_n;
  logic [ROWS-1:0] rs_n;
  logic            wr_n;
  logic [DW-1:0]   d_n;
  logic            ack0_n;
  logic            ack1_n;
  logic            err_n;
  logic            busy_n;
  logic [DW-1:0]   rdata_n;

  logic            pick;
  logic            g_we;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wd;
  logic [ROWS:0]   g_dec;

  // Top bit flags an in-range address; low bits are the row one-hot.
  function automatic logic [ROWS:0] decode(input logic [AW-1:0] a);
    logic [ROWS:0] r;
    r = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (a == AW'(i)) begin
        r[i]    = 1'b1;
        r[ROWS] = 1'b1;
      end
    end
    return r;
  endfunction

  // Grant: a lone request wins; on a tie, the one not granted last.
  always_comb begin
    pick   = req1 & (~req0 | ~last);
    g_we   = pick ? we1 : we0;
    g_addr = pick ? addr1 : addr0;
    g_wd   = pick ? wd1 : wd0;
    g_dec  = decode(g_addr);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n = state;
    last_n  = last;
    gnt_n   = gnt;
    op_we_n = op_we;
    op_ok_n = op_ok;
    rs_n    = rs;
    wr_n    = 1'b0;
    d_n     = d;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    err_n   = 1'b0;
    rdata_n = rdata;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_n = SETUP;
          gnt_n   = pick;
          last_n  = pick;
          op_we_n = g_we;
          op_ok_n = g_dec[ROWS];
          rs_n    = g_dec[ROWS-1:0];
          d_n     = g_wd;
        end
      end
      SETUP: begin
        state_n = op_we ? STROBE : SAMPLE;
        wr_n    = op_we;
      end
      STROBE: begin
        state_n = HOLD;
      end
      HOLD: begin
        state_n = DONE;
        rs_n    = '0;
        ack0_n  = ~gnt;
        ack1_n  = gnt;
        err_n   = ~op_ok;
      end
      SAMPLE: begin
        state_n = DONE;
        rs_n    = '0;
        ack0_n  = ~gnt;
        ack1_n  = gnt;
        err_n   = ~op_ok;
        rdata_n = op_ok ? mq : '0;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge ck) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 1'b0;
      op_we <= 1'b0;
      op_ok <= 1'b0;
      rs    <= '0;
      wr    <= 1'b0;
      d     <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      gnt   <= gnt_n;
      op_we <= op_we_n;
      op_ok <= op_ok_n;
      rs    <= rs_n;
      wr    <= wr_n;
      d     <= d_n;
      ack0  <= ack0_n;
      ack1  <= ack1_n;
      err   <= err_n;
      busy  <= busy_n;
      rdata <= rdata_n;
    end
  end

endmodule
